// File: rtl/imem_loader.sv
// imem_loader
//   Byte-serial program loader for the CPU's word-addressed instruction memory.
//   It parses a host byte stream framed as SYNC, LEN_LO, LEN_HI, LEN
//   little-endian 32-bit words, and an optional CSUM byte. It writes each
//   word into IM and keeps the CPU in reset until a complete, valid image
//   has been written.
//
// Configuration macro
//   LOADER_CSUM_EN : when defined, a trailing CSUM byte is expected. CSUM is
//                    the XOR of the LEN bytes and all data bytes, and a
//                    mismatch rejects the frame. When undefined, the frame
//                    ends after the last word.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous reset, active-low
//   in_valid_i   host byte valid
//   in_data_i    host byte
//   in_ready_o   byte accepted when in_valid_i & in_ready_o
//   start_i      re-arm request, honoured only in DONE/ERR
//   im_we_o      IM write strobe, one cycle per word
//   im_addr_o    IM word address
//   im_wdata_o   IM write data
//   cpu_rst_o    active-high CPU reset
//   done_o       image loaded and accepted (level)
//   error_o      frame rejected (level)
module imem_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  input  logic [7:0]        in_data_i,
  output logic              in_ready_o,
  input  logic              start_i,
  output logic              im_we_o,
  output logic [ADDR_W-1:0] im_addr_o,
  output logic [31:0]       im_wdata_o,
  output logic              cpu_rst_o,
  output logic              done_o,
  output logic              error_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
`ifdef LOADER_CSUM_EN
    S_CSUM   = 3'd4,
`endif
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_e;

  // Where the frame goes once the payload (possibly empty) is complete.
`ifdef LOADER_CSUM_EN
  localparam state_e S_AFTER_DATA = S_CSUM;
`else
  localparam state_e S_AFTER_DATA = S_DONE;
`endif

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  // Largest word count that fits between BASE_ADDR and the top of IM.
  localparam logic [16:0]       MAX_LEN = 17'((32'd1 << ADDR_W) - BASE_ADDR);

  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_e              state_q, state_d;
  logic [7:0]          len_lo_q, len_lo_d;
  logic [15:0]         words_left_q, words_left_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [23:0]         word_q, word_d;
  logic [7:0]          csum_q, csum_d;
  logic                im_we_q, im_we_d;
  logic [ADDR_W-1:0]   im_addr_q, im_addr_d;
  logic [31:0]         im_wdata_q, im_wdata_d;
  logic                accept_s;
  logic [15:0]         len_s;

  assign accept_s = in_valid_i & in_ready_o;
  assign len_s    = {in_data_i, len_lo_q};

  // State and datapath registers; reset returns to IDLE with the CPU held in reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      len_lo_q     <= 8'h00;
      words_left_q <= 16'h0000;
      byte_cnt_q   <= 2'd0;
      word_q       <= 24'h000000;
      csum_q       <= 8'h00;
      im_we_q      <= 1'b0;
      im_addr_q    <= BASE;
      im_wdata_q   <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      words_left_q <= words_left_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      csum_q       <= csum_d;
      im_we_q      <= im_we_d;
      im_addr_q    <= im_addr_d;
      im_wdata_q   <= im_wdata_d;
    end
  end

  // Next-state and datapath update for the frame parser.
  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    words_left_d = words_left_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    csum_d       = csum_q;
    im_we_d      = 1'b0;
    im_wdata_d   = im_wdata_q;

    // Advance the address after a write only while words remain, so the
    // pointer never steps past the last word of the image.
    if (im_we_q && (words_left_q != 16'd0)) begin
      im_addr_d = im_addr_q + ADDR_W'(1);
    end else begin
      im_addr_d = im_addr_q;
    end

    case (state_q)
      S_IDLE: begin
        if (accept_s && (in_data_i == SYNC_BYTE)) begin
          state_d = S_LEN_LO;
          csum_d  = 8'h00;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LEN_LO: begin
        if (accept_s) begin
          len_lo_d = in_data_i;
          csum_d   = csum_step(csum_q, in_data_i);
          state_d  = S_LEN_HI;
        end else begin
          state_d  = S_LEN_LO;
        end
      end
      S_LEN_HI: begin
        if (accept_s) begin
          csum_d       = csum_step(csum_q, in_data_i);
          words_left_d = len_s;
          byte_cnt_d   = 2'd0;
          if ({1'b0, len_s} > MAX_LEN) begin
            state_d = S_ERR;
          end else if (len_s == 16'd0) begin
            state_d = S_AFTER_DATA;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_LEN_HI;
        end
      end
      S_DATA: begin
        if (accept_s) begin
          csum_d = csum_step(csum_q, in_data_i);
          case (byte_cnt_q)
            2'd0:    word_d[7:0]   = in_data_i;
            2'd1:    word_d[15:8]  = in_data_i;
            2'd2:    word_d[23:16] = in_data_i;
            default: begin
              // Last byte of the word: launch the write on the next cycle.
              im_we_d      = 1'b1;
              im_wdata_d   = {in_data_i, word_q};
              words_left_d = words_left_q - 16'd1;
            end
          endcase
          byte_cnt_d = byte_cnt_q + 2'd1;
          if ((byte_cnt_q == 2'd3) && (words_left_q == 16'd1)) begin
            state_d = S_AFTER_DATA;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef LOADER_CSUM_EN
      S_CSUM: begin
        if (accept_s) begin
          if (in_data_i == csum_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERR;
          end
        end else begin
          state_d = S_CSUM;
        end
      end
`endif
      S_DONE, S_ERR: begin
        if (start_i) begin
          state_d      = S_IDLE;
          im_addr_d    = BASE;
          csum_d       = 8'h00;
          words_left_d = 16'd0;
          byte_cnt_d   = 2'd0;
          word_d       = 24'h000000;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        // Unreachable encodings park in ERR so the CPU stays in reset.
        state_d = S_ERR;
      end
    endcase
  end

  // Status and handshake decode from the registered state.
  always_comb begin
    in_ready_o = 1'b1;
    cpu_rst_o  = 1'b1;
    done_o     = 1'b0;
    error_o    = 1'b0;
    case (state_q)
      S_DONE: begin
        in_ready_o = 1'b0;
        cpu_rst_o  = 1'b0;
        done_o     = 1'b1;
      end
      S_ERR: begin
        in_ready_o = 1'b0;
        error_o    = 1'b1;
      end
      default: begin
        in_ready_o = 1'b1;
        cpu_rst_o  = 1'b1;
      end
    endcase
  end

  assign im_we_o    = im_we_q;
  assign im_addr_o  = im_addr_q;
  assign im_wdata_o = im_wdata_q;

endmodule
